ucode_sequencer: RTL and testbench

//  Micro-program counter and dispatch controller for the bytecode execution core.

---
 rtl/jvm_ucode_pkg.sv | 17 +
 rtl/ucode_sequencer.sv | 136 +++++++++++++
 tb/tb_ucode_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/jvm_ucode_pkg.sv
// Shared constants for the bytecode micro-sequencer: micro-address layout,
// trap causes and the FSM state encoding.
package jvm_ucode_pkg;

   localparam int unsigned UA_W       = 9;
   localparam logic [8:0]  UA_DONE    = 9'h000;
   localparam logic [8:0]  UA_ILLEGAL = 9'h1FF;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_WDOG    = 2'd2;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_TRAP  = 2'd2;

endpackage

// File: rtl/ucode_sequencer.sv
// Micro-program counter: dispatches a JVM opcode to {0,opcode}, follows the
// next-address ROM chain to 0, and traps on illegal entries or runaway chains.
module ucode_sequencer #(
   parameter int unsigned UA_W      = jvm_ucode_pkg::UA_W,
   parameter int unsigned MAX_STEPS = 64,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bc_valid,
   input  logic [7:0]       bc_opcode,
   output logic             bc_ready,
   input  logic             flush,
   input  logic             stall,
   output logic [UA_W-1:0]  upc,
   input  logic [UA_W-1:0]  rom_next,
   output logic             uop_valid,
   output logic             instr_done,
   output logic             trap,
   output logic [1:0]       trap_cause,
   input  logic             trap_clr,
   output logic [CNT_W-1:0] instr_cnt
);
   import jvm_ucode_pkg::*;

   localparam int unsigned SW = $clog2(MAX_STEPS + 1);

   logic [1:0]       state_q, state_d;
   logic [UA_W-1:0]  upc_q, upc_d;
   logic             uop_valid_q, uop_valid_d;
   logic             done_q, done_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    step_q, step_d;
   logic             ready;

   always_comb begin
      state_d     = state_q;
      upc_d       = upc_q;
      uop_valid_d = uop_valid_q;
      done_d      = 1'b0;
      trap_d      = trap_q;
      cause_d     = cause_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      ready       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ready = 1'b1;
            if (bc_valid) begin
               upc_d       = UA_W'(bc_opcode);
               step_d      = SW'(1);
               uop_valid_d = 1'b1;
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Priority: flush, then stall, then completion, then faults, then advance.
            if (flush) begin
               uop_valid_d = 1'b0;
               state_d     = ST_FETCH;
            end else if (!stall) begin
               if (rom_next == UA_W'(UA_DONE)) begin
                  done_d = 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
                  ready  = 1'b1;
                  if (bc_valid) begin
                     upc_d  = UA_W'(bc_opcode);
                     step_d = SW'(1);
                  end else begin
                     uop_valid_d = 1'b0;
                     state_d     = ST_FETCH;
                  end
               end else if (rom_next == UA_W'(UA_ILLEGAL)) begin
                  trap_d      = 1'b1;
                  cause_d     = CAUSE_ILLEGAL;
                  uop_valid_d = 1'b0;
                  state_d     = ST_TRAP;
               end else if (step_q == SW'(MAX_STEPS)) begin
                  trap_d      = 1'b1;
                  cause_d     = CAUSE_WDOG;
                  uop_valid_d = 1'b0;
                  state_d     = ST_TRAP;
               end else begin
                  upc_d  = rom_next;
                  step_d = step_q + SW'(1);
               end
            end
         end
         ST_TRAP: begin
            uop_valid_d = 1'b0;
            if (trap_clr) begin
               trap_d  = 1'b0;
               cause_d = CAUSE_NONE;
               state_d = ST_FETCH;
            end
         end
         default: begin
            uop_valid_d = 1'b0;
            state_d     = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         upc_q       <= '0;
         uop_valid_q <= 1'b0;
         done_q      <= 1'b0;
         trap_q      <= 1'b0;
         cause_q     <= CAUSE_NONE;
         cnt_q       <= '0;
         step_q      <= '0;
      end else begin
         state_q     <= state_d;
         upc_q       <= upc_d;
         uop_valid_q <= uop_valid_d;
         done_q      <= done_d;
         trap_q      <= trap_d;
         cause_q     <= cause_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
      end
   end

   assign bc_ready   = ready;
   assign upc        = upc_q;
   assign uop_valid  = uop_valid_q;
   assign instr_done = done_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a behavioural next-address ROM and a
// queue of expected micro-addresses popped on every live micro-op.
module tb_ucode_sequencer;

   logic        clk;
   logic        rst;
   logic        bc_valid, flush, stall, trap_clr;
   logic [7:0]  bc_opcode;
   logic        bc_ready, uop_valid, instr_done, trap;
   logic [8:0]  upc, rom_next;
   logic [1:0]  trap_cause;
   logic [31:0] instr_cnt;

   logic        bc_valid2;
   logic [7:0]  bc_opcode2;
   logic        bc_ready2, uop_valid2, instr_done2, trap2;
   logic [8:0]  upc2, rom_next2;
   logic [1:0]  trap_cause2;
   logic [31:0] instr_cnt2;

   logic        stub;
   logic [8:0]  exp_q[$];
   int          checks;
   int          errors;
   int          done_cnt;

   function automatic logic [8:0] rom(input logic [8:0] a);
      case (a)
         9'h059:  rom = 9'h100;
         9'h100:  rom = 9'h101;
         9'h05A:  rom = 9'h104;
         9'h030:  rom = 9'h134;
         9'h134:  rom = 9'h135;
         9'h135:  rom = 9'h115;
         9'h115:  rom = 9'h10C;
         default: rom = 9'h000;
      endcase
   endfunction

   assign rom_next  = stub ? 9'h1FF : rom(upc);
   assign rom_next2 = rom(upc2);

   ucode_sequencer dut (
      .clk(clk), .rst(rst), .bc_valid(bc_valid), .bc_opcode(bc_opcode),
      .bc_ready(bc_ready), .flush(flush), .stall(stall), .upc(upc),
      .rom_next(rom_next), .uop_valid(uop_valid), .instr_done(instr_done),
      .trap(trap), .trap_cause(trap_cause), .trap_clr(trap_clr),
      .instr_cnt(instr_cnt)
   );

   ucode_sequencer #(.MAX_STEPS(4)) dut_wd (
      .clk(clk), .rst(rst), .bc_valid(bc_valid2), .bc_opcode(bc_opcode2),
      .bc_ready(bc_ready2), .flush(1'b0), .stall(1'b0), .upc(upc2),
      .rom_next(rom_next2), .uop_valid(uop_valid2), .instr_done(instr_done2),
      .trap(trap2), .trap_cause(trap_cause2), .trap_clr(1'b0),
      .instr_cnt(instr_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at the falling edge and retire a scoreboard entry per live micro-op.
   task automatic cyc();
      @(negedge clk);
      if (instr_done === 1'b1) done_cnt++;
      if (uop_valid === 1'b1) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("upc", 32'(upc), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      checks = 0; errors = 0; done_cnt = 0;
      rst = 1'b1; stub = 1'b0;
      bc_valid = 1'b0; bc_opcode = 8'h00; flush = 1'b0; stall = 1'b0; trap_clr = 1'b0;
      bc_valid2 = 1'b0; bc_opcode2 = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_upc", 32'(upc), 32'h0);
      chk("rst_uop_valid", 32'(uop_valid), 32'h0);
      chk("rst_instr_done", 32'(instr_done), 32'h0);
      chk("rst_trap", 32'(trap), 32'h0);
      chk("rst_cause", 32'(trap_cause), 32'h0);
      chk("rst_cnt", instr_cnt, 32'h0);
      chk("rst_ready", 32'(bc_ready), 32'h1);
      rst = 1'b0;

      // Opcode 0x00: single micro-op
      exp_q.push_back(9'h000);
      bc_valid = 1'b1; bc_opcode = 8'h00;
      cyc();
      bc_valid = 1'b0;
      chk("op00_last_ready", 32'(bc_ready), 32'h1);
      cyc();
      chk("op00_done", 32'(instr_done), 32'h1);
      chk("op00_cnt", instr_cnt, 32'd1);
      chk("op00_idle", 32'(uop_valid), 32'h0);

      // Opcode 0x59: three micro-ops
      exp_q.push_back(9'h059); exp_q.push_back(9'h100); exp_q.push_back(9'h101);
      bc_valid = 1'b1; bc_opcode = 8'h59;
      cyc();
      bc_valid = 1'b0;
      chk("op59_busy_ready", 32'(bc_ready), 32'h0);
      cyc();
      cyc();
      chk("op59_done_early", 32'(done_cnt), 32'd1);
      cyc();
      chk("op59_done", 32'(instr_done), 32'h1);
      chk("op59_cnt", instr_cnt, 32'd2);
      chk("op59_sb_empty", 32'(exp_q.size()), 32'd0);

      // 0x59 then 0x5A back-to-back with no bubble
      exp_q.push_back(9'h059); exp_q.push_back(9'h100); exp_q.push_back(9'h101);
      exp_q.push_back(9'h05A); exp_q.push_back(9'h104);
      bc_valid = 1'b1; bc_opcode = 8'h59;
      cyc();
      bc_opcode = 8'h5A;
      cyc();
      cyc();
      chk("b2b_last_ready", 32'(bc_ready), 32'h1);
      cyc();
      bc_valid = 1'b0;
      chk("b2b_first_done", 32'(instr_done), 32'h1);
      cyc();
      cyc();
      chk("b2b_cnt", instr_cnt, 32'd4);
      chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("b2b_done_total", 32'(done_cnt), 32'd4);

      // Opcode 0x30 with a two-cycle stall on 0x135
      exp_q.push_back(9'h030); exp_q.push_back(9'h134);
      exp_q.push_back(9'h135); exp_q.push_back(9'h135); exp_q.push_back(9'h135);
      exp_q.push_back(9'h115); exp_q.push_back(9'h10C);
      bc_valid = 1'b1; bc_opcode = 8'h30;
      cyc();
      bc_valid = 1'b0;
      cyc();
      cyc();
      stall = 1'b1;
      cyc();
      cyc();
      stall = 1'b0;
      cyc();
      cyc();
      chk("stall_last_ready", 32'(bc_ready), 32'h1);
      cyc();
      chk("stall_done", 32'(instr_done), 32'h1);
      chk("stall_cnt", instr_cnt, 32'd5);
      chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

      // Flush while upc=0x134
      exp_q.push_back(9'h030); exp_q.push_back(9'h134);
      bc_valid = 1'b1; bc_opcode = 8'h30;
      cyc();
      bc_valid = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_idle", 32'(uop_valid), 32'h0);
      chk("flush_ready", 32'(bc_ready), 32'h1);
      chk("flush_no_done", 32'(instr_done), 32'h0);
      chk("flush_cnt", instr_cnt, 32'd5);
      chk("flush_sb_empty", 32'(exp_q.size()), 32'd0);

      // Stub ROM returning the illegal entry
      stub = 1'b1;
      exp_q.push_back(9'h010);
      bc_valid = 1'b1; bc_opcode = 8'h10;
      cyc();
      bc_valid = 1'b0;
      cyc();
      chk("ill_trap", 32'(trap), 32'h1);
      chk("ill_cause", 32'(trap_cause), 32'd1);
      chk("ill_ready", 32'(bc_ready), 32'h0);
      chk("ill_upc", 32'(upc), 32'h010);
      bc_valid = 1'b1; bc_opcode = 8'h00; flush = 1'b1;
      cyc();
      bc_valid = 1'b0; flush = 1'b0; stub = 1'b0;
      chk("ill_hold_trap", 32'(trap), 32'h1);
      chk("ill_hold_uop", 32'(uop_valid), 32'h0);
      chk("ill_hold_ready", 32'(bc_ready), 32'h0);
      trap_clr = 1'b1;
      cyc();
      trap_clr = 1'b0;
      chk("clr_trap", 32'(trap), 32'h0);
      chk("clr_cause", 32'(trap_cause), 32'd0);
      chk("clr_ready", 32'(bc_ready), 32'h1);
      chk("clr_cnt", instr_cnt, 32'd5);

      // Watchdog instance (MAX_STEPS=4) on opcode 0x30
      bc_valid2 = 1'b1; bc_opcode2 = 8'h30;
      cyc();
      bc_valid2 = 1'b0;
      chk("wd_first_upc", 32'(upc2), 32'h030);
      cyc();
      cyc();
      cyc();
      chk("wd_pre_upc", 32'(upc2), 32'h115);
      chk("wd_pre_trap", 32'(trap2), 32'h0);
      cyc();
      chk("wd_trap", 32'(trap2), 32'h1);
      chk("wd_cause", 32'(trap_cause2), 32'd2);
      chk("wd_upc", 32'(upc2), 32'h115);
      chk("wd_uop", 32'(uop_valid2), 32'h0);
      chk("wd_ready", 32'(bc_ready2), 32'h0);
      chk("wd_done", 32'(instr_done2), 32'h0);
      chk("wd_cnt", instr_cnt2, 32'd0);

      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("final_done_total", 32'(done_cnt), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
